window_scan_ctrl: RTL and testbench

Sequencing controller for the 3x3 sliding-window generator. On `start` it scans one or more image channels from the on-chip pixel RAM, emits each channel as a zero-bordered (IMG_WIDTH+2)^2 raster stream with valid/ready flow control, and counts the windows the generator hands downstream. Between channels it clears the generator; after the last channel it pulses `done`. It sits between the feature-map RAM and the window generator in the convolution front end.

---
 rtl/window_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// Sequencer that scans image channels from pixel RAM as zero-bordered raster streams for the 3x3 window generator.
// Optional build macro WIN_SCAN_STALL_CNT_EN adds the 32-bit stall_cycles backpressure counter.
module window_scan_ctrl #(
  parameter int IMG_WIDTH = 128,
  parameter int STRIDE    = 1,
  parameter int CHANNELS  = 1,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cur_ch,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              win_start,
  output logic              win_clear,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  input  logic              win_accept
`ifdef WIN_SCAN_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PW           = IMG_WIDTH + 2;
  localparam int WIN_PER_AXIS = (IMG_WIDTH - 1) / STRIDE + 1;
  localparam logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(IMG_WIDTH * IMG_WIDTH);
  localparam logic [8:0]        POS_LAST  = 9'(PW - 1);
  localparam logic [16:0]       WIN_EXP   = 17'(WIN_PER_AXIS * WIN_PER_AXIS);
  localparam logic [7:0]        CH_LAST   = 8'(CHANNELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_NEXT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [8:0]        row_p0, col_p0;
  logic [ADDR_W-1:0] ch_base, pix_off;
  logic [16:0]       win_cnt;
  logic              vld_p0, border_p0, last_p0;
  logic              vld_p1, border_p1;
  logic [7:0]        fifo_q [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              push, pop, start_acc;
  logic [2:0]        occ_after_pop;

  assign start_acc = (state == S_IDLE) && start;
  assign pop       = pix_valid && pix_ready;
  assign push      = vld_p1;
  // Credit counts the slot freed by this cycle's pop so a full-rate stream never stalls.
  assign occ_after_pop = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};

  // Stage p0: beat issue
  assign border_p0   = (row_p0 == 9'd0) || (row_p0 == POS_LAST) ||
                       (col_p0 == 9'd0) || (col_p0 == POS_LAST);
  assign last_p0     = (row_p0 == POS_LAST) && (col_p0 == POS_LAST);
  assign vld_p0      = (state == S_RUN) && (occ_after_pop < 3'd2);
  assign mem_rd_en   = vld_p0 && !border_p0;
  assign mem_rd_addr = mem_rd_en ? (ch_base + pix_off) : '0;
  assign pix_valid   = (fifo_cnt != 2'd0);
  assign pix_data    = fifo_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    win_start = 1'b0;
    win_clear = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy      = 1'b1;
        win_start = 1'b1;
        if (vld_p0 && last_p0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        win_start = 1'b1;
        if ((fifo_cnt == 2'd0) && !vld_p1 && (win_cnt == WIN_EXP)) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        win_clear = 1'b1;
        state_nxt = (cur_ch == CH_LAST) ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_p0  <= '0;
      col_p0  <= '0;
      ch_base <= '0;
      pix_off <= '0;
      win_cnt <= '0;
      cur_ch  <= '0;
    end else if (start_acc) begin
      ch_base <= base_addr;
      cur_ch  <= '0;
      row_p0  <= '0;
      col_p0  <= '0;
      pix_off <= '0;
      win_cnt <= '0;
    end else if (state == S_NEXT) begin
      row_p0  <= '0;
      col_p0  <= '0;
      pix_off <= '0;
      win_cnt <= '0;
      if (cur_ch != CH_LAST) begin
        cur_ch  <= cur_ch + 8'd1;
        ch_base <= ch_base + CH_STRIDE;
      end
    end else begin
      if (vld_p0) begin
        if (col_p0 == POS_LAST) begin
          col_p0 <= '0;
          row_p0 <= row_p0 + 9'd1;
        end else begin
          col_p0 <= col_p0 + 9'd1;
        end
        if (!border_p0) pix_off <= pix_off + 1'b1;
      end
      // Saturate so surplus handshakes in DRAIN cannot wrap the count.
      if (win_start && win_accept && (win_cnt != WIN_EXP)) win_cnt <= win_cnt + 17'd1;
    end
  end

  // Stage p1: border tag alongside the RAM read, then 2-entry output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      vld_p1    <= vld_p0;
      border_p1 <= border_p0;
      if (push) begin
        fifo_q[wr_ptr] <= border_p1 ? 8'd0 : mem_rd_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef WIN_SCAN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          stall_cycles <= '0;
    else if (start_acc)                                  stall_cycles <= '0;
    else if (pix_valid && !pix_ready && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: a 3-channel stride-1 instance checked against a raster model, plus a stride-2 instance.
module tb_window_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, start_a, busy_a, done_a, rd_en_a, win_start_a, win_clear_a, pv_a, pr_a, wa_a;
  logic [15:0] base_a, rd_addr_a;
  logic [7:0]  cur_ch_a, rd_data_a, pd_a;
  logic        rst_n_b, start_b, busy_b, done_b, rd_en_b, win_start_b, win_clear_b, pv_b, pr_b, wa_b;
  logic [15:0] base_b, rd_addr_b;
  logic [7:0]  cur_ch_b, rd_data_b, pd_b;
`ifdef WIN_SCAN_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  window_scan_ctrl #(.IMG_WIDTH(4), .STRIDE(1), .CHANNELS(3), .ADDR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .base_addr(base_a), .busy(busy_a), .done(done_a),
    .cur_ch(cur_ch_a), .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(rd_data_a),
    .win_start(win_start_a), .win_clear(win_clear_a), .pix_valid(pv_a), .pix_ready(pr_a),
    .pix_data(pd_a), .win_accept(wa_a)
`ifdef WIN_SCAN_STALL_CNT_EN
    , .stall_cycles(stall_a)
`endif
  );

  window_scan_ctrl #(.IMG_WIDTH(4), .STRIDE(2), .CHANNELS(1), .ADDR_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .base_addr(base_b), .busy(busy_b), .done(done_b),
    .cur_ch(cur_ch_b), .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(rd_data_b),
    .win_start(win_start_b), .win_clear(win_clear_b), .pix_valid(pv_b), .pix_ready(pr_b),
    .pix_data(pd_b), .win_accept(wa_b)
`ifdef WIN_SCAN_STALL_CNT_EN
    , .stall_cycles(stall_b)
`endif
  );

  // Pixel RAM whose content is the low byte of the address, one cycle read latency.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= rd_addr_a[7:0];
    if (rd_en_b) rd_data_b <= rd_addr_b[7:0];
  end

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected stream for base 0x0100, 3 channels of a 4x4 image padded to 6x6.
  logic [7:0]  exp_beat [0:107];
  int          exp_ch   [0:107];
  bit          exp_int  [0:107];
  logic [15:0] exp_addr [0:47];
  logic [7:0]  obs      [0:107];

  int   rmode = 0;
  int   acc_target = 16;
  int   acc_sent = 0;
  always @(posedge clk) begin
    #2;
    pr_a = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    pr_b = 1'b1;
    if (!rst_n_a || win_clear_a) acc_sent = 0;
    if (rst_n_a && win_start_a && (acc_sent < acc_target)) begin
      wa_a = 1'b1;
      acc_sent++;
    end else begin
      wa_a = 1'b0;
    end
  end

  int          bi, ri, outstanding, n_done_a, n_clear_a, stall_seen;
  bit          hold_v, prev_clear, pbusy_a, seen2;
  logic [7:0]  hold_d;
  logic [15:0] ch2_first;
  initial begin
    bi = 0; ri = 0; outstanding = 0; n_done_a = 0; n_clear_a = 0; stall_seen = 0;
    hold_v = 0; prev_clear = 0; pbusy_a = 0; seen2 = 0; hold_d = 0; ch2_first = 0;
  end

  always @(negedge clk) begin
    if (!rst_n_a) begin
      hold_v = 0; outstanding = 0; prev_clear = 0; pbusy_a = 0;
    end else begin
      if (busy_a && !pbusy_a) begin
        bi = 0; ri = 0; outstanding = 0; seen2 = 0; stall_seen = 0;
      end
      pbusy_a = busy_a;
      if (hold_v) begin
        chk("hold_valid", pv_a, 1'b1);
        chk("hold_data", pd_a, hold_d);
      end
      if (pv_a && pr_a) begin
        if (bi >= 108) chk("extra_beat", bi, 107);
        else begin
          chk("beat_data", pd_a, exp_beat[bi]);
          chk("beat_ch", cur_ch_a, exp_ch[bi]);
          if (exp_int[bi]) outstanding--;
          obs[bi] = pd_a;
          bi++;
        end
      end
      if (rd_en_a) begin
        chk("rd_credit", outstanding < 2, 1'b1);
        if (ri >= 48) chk("extra_read", ri, 47);
        else begin
          chk("rd_addr", rd_addr_a, exp_addr[ri]);
          ri++;
        end
        if (cur_ch_a == 8'd2 && !seen2) begin
          ch2_first = rd_addr_a;
          seen2 = 1;
        end
        outstanding++;
      end
      if (done_a) begin
        n_done_a++;
        chk("done_after_clear", prev_clear, 1'b1);
        chk("done_busy_low", busy_a, 1'b0);
      end
      if (win_clear_a) begin
        n_clear_a++;
        chk("clear_no_read", rd_en_a, 1'b0);
      end
      prev_clear = win_clear_a;
      hold_v = pv_a && !pr_a;
      hold_d = pd_a;
      if (pv_a && !pr_a) stall_seen++;
    end
  end

  int  bi_b = 0;
  int  n_done_b = 0;
  int  n_clear_b = 0;
  bit  pbusy_b = 0;
  always @(negedge clk) begin
    int r, c;
    logic [7:0] e;
    if (!rst_n_b) pbusy_b = 0;
    else begin
      if (busy_b && !pbusy_b) bi_b = 0;
      pbusy_b = busy_b;
      if (done_b) n_done_b++;
      if (win_clear_b) n_clear_b++;
      if (pv_b && pr_b) begin
        r = bi_b / 6;
        c = bi_b % 6;
        e = (r >= 1 && r <= 4 && c >= 1 && c <= 4) ? 8'((r - 1) * 4 + c - 1) : 8'd0;
        chk("b_beat", pd_b, e);
        bi_b++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_a(input logic [15:0] b);
    base_a = b;
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input string nm);
    int d0, n;
    d0 = n_done_a;
    n = 0;
    while (n_done_a == d0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk(nm, n_done_a - d0, 1);
  endtask

  task automatic chk_reset_a(input string p);
    chk({p, "_busy"}, busy_a, 1'b0);
    chk({p, "_done"}, done_a, 1'b0);
    chk({p, "_cur_ch"}, cur_ch_a, 8'd0);
    chk({p, "_rd_en"}, rd_en_a, 1'b0);
    chk({p, "_rd_addr"}, rd_addr_a, 16'd0);
    chk({p, "_win_start"}, win_start_a, 1'b0);
    chk({p, "_win_clear"}, win_clear_a, 1'b0);
    chk({p, "_pix_valid"}, pv_a, 1'b0);
    chk({p, "_pix_data"}, pd_a, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d_done, d_clr, n;
    logic [15:0] a;
    start_a = 0; base_a = 0; start_b = 0; base_b = 0; wa_b = 0;
    rst_n_a = 0; rst_n_b = 0;
    k = 0;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          exp_ch[ch * 36 + r * 6 + c] = ch;
          if (r >= 1 && r <= 4 && c >= 1 && c <= 4) begin
            a = 16'h0100 + 16'(ch * 16 + (r - 1) * 4 + (c - 1));
            exp_beat[ch * 36 + r * 6 + c] = a[7:0];
            exp_int[ch * 36 + r * 6 + c]  = 1'b1;
            exp_addr[k] = a;
            k++;
          end else begin
            exp_beat[ch * 36 + r * 6 + c] = 8'd0;
            exp_int[ch * 36 + r * 6 + c]  = 1'b0;
          end
        end

    cyc(3);
    @(negedge clk);
    chk_reset_a("rst");
    cyc(1);
    rst_n_a = 1; rst_n_b = 1;
    cyc(2);

    // Full-rate scan with a stray start while busy.
    d_done = n_done_a; d_clr = n_clear_a;
    pulse_start_a(16'h0100);
    @(negedge clk);
    chk("t1_busy", busy_a, 1'b1);
    chk("t1_win_start", win_start_a, 1'b1);
    chk("t1_valid", pv_a, 1'b0);
    @(negedge clk);
    chk("t2_valid", pv_a, 1'b0);
    @(negedge clk);
    chk("t3_valid", pv_a, 1'b1);
    chk("t3_data", pd_a, 8'd0);
    cyc(4);
    pulse_start_a(16'h0300);
    wait_done_a(2000, "s1_done");
    cyc(4);
    chk("s1_beats", bi, 108);
    chk("s1_reads", ri, 48);
    chk("s1_done_cnt", n_done_a - d_done, 1);
    chk("s1_clears", n_clear_a - d_clr, 3);
    chk("beat_0_0", obs[0], 8'h00);
    chk("beat_1_1", obs[7], 8'h00);
    chk("beat_4_4", obs[28], 8'h0F);
    chk("beat_5_5", obs[35], 8'h00);
    chk("beat_ch1_1_1", obs[43], 8'h10);
    chk("ch2_first_rd", ch2_first, 16'h0120);
    chk("s1_idle_busy", busy_a, 1'b0);

    // Random backpressure with surplus window handshakes.
    d_done = n_done_a; d_clr = n_clear_a;
    acc_target = 20;
    rmode = 1;
    pulse_start_a(16'h0100);
    wait_done_a(3000, "s2_done");
    rmode = 0;
    cyc(4);
    chk("s2_beats", bi, 108);
    chk("s2_done_cnt", n_done_a - d_done, 1);
    chk("s2_clears", n_clear_a - d_clr, 3);
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("s2_stall_cycles", stall_a, stall_seen);
`endif

    // Asynchronous reset in the middle of channel 1, then a fresh scan.
    acc_target = 16;
    pulse_start_a(16'h0100);
    n = 0;
    while (cur_ch_a != 8'd1 && n < 500) begin
      cyc(1);
      n++;
    end
    chk("s3_reach_ch1", cur_ch_a, 8'd1);
    cyc(8);
    #2;
    rst_n_a = 0;
    #1;
    chk_reset_a("mid_rst");
    cyc(2);
    chk_reset_a("held_rst");
    rst_n_a = 1;
    cyc(2);
    d_done = n_done_a; d_clr = n_clear_a;
    pulse_start_a(16'h0100);
    @(negedge clk);
    chk("s3_restart_ch", cur_ch_a, 8'd0);
    chk("s3_restart_busy", busy_a, 1'b1);
    wait_done_a(2000, "s3_done");
    cyc(4);
    chk("s3_beats", bi, 108);
    chk("s3_done_cnt", n_done_a - d_done, 1);
    chk("s3_clears", n_clear_a - d_clr, 3);

    // Ten cycles of pix_ready low while the stream is valid.
    pulse_start_a(16'h0100);
    n = 0;
    while (!pv_a && n < 10) begin
      cyc(1);
      n++;
    end
    chk("s4_valid_seen", pv_a, 1'b1);
    rmode = 2;
    cyc(10);
    rmode = 0;
    wait_done_a(2000, "s4_done");
    cyc(4);
    chk("s4_beats", bi, 108);
    chk("s4_stall_model", stall_seen, 10);
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("s4_stall_cycles", stall_a, 32'd10);
`endif

    // Stride 2: four windows expected; handshakes while idle must not count.
    wa_b = 1;
    cyc(4);
    wa_b = 0;
    base_b = 16'h0000;
    start_b = 1;
    cyc(1);
    start_b = 0;
    cyc(2);
    wa_b = 1;
    cyc(3);
    wa_b = 0;
    cyc(60);
    chk("b_no_done_at_3", n_done_b, 0);
    chk("b_busy_at_3", busy_b, 1'b1);
    chk("b_beats", bi_b, 36);
    wa_b = 1;
    cyc(1);
    wa_b = 0;
    n = 0;
    while (n_done_b == 0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("b_done_at_4", n_done_b, 1);
    cyc(4);
    chk("b_single_done", n_done_b, 1);
    chk("b_clears", n_clear_b, 1);
    chk("b_idle_busy", busy_b, 1'b0);
    chk("b_idle_win_start", win_start_b, 1'b0);
    chk("b_cur_ch", cur_ch_b, 8'd0);
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("b_stall_cycles", stall_b, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
